// File: rtl/point_pack_if.sv
// Candidate request, image-memory read port and packed point result for point_pack.
// The slave modport is the sampler's view; the master modport drives candidates and serves memory.
interface point_pack_if #(
    parameter int WIDTH = 8,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int AW    = 19
);
    logic                 start;
    logic [XW-1:0]        cand_x;
    logic [YW-1:0]        cand_y;
    logic                 busy;
    logic                 mem_rd;
    logic [AW-1:0]        mem_addr;
    logic [WIDTH-1:0]     mem_data;
    logic [WIDTH*9-1:0]   point_val;
    logic                 pv_valid;
    logic [XW-1:0]        pv_x;
    logic [YW-1:0]        pv_y;

    modport slave (
        input  start, cand_x, cand_y, mem_data,
        output busy, mem_rd, mem_addr, point_val, pv_valid, pv_x, pv_y
    );

    modport master (
        output start, cand_x, cand_y, mem_data,
        input  busy, mem_rd, mem_addr, point_val, pv_valid, pv_x, pv_y
    );
endinterface

// File: rtl/point_pack.sv
// Nine-point candidate sampler: reads centre, inner ring and outer ring pixels and packs them.
// Define POINT_PACK_CLAMP_EN to clamp off-image points to the border instead of packing zero.
module point_pack #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int AW    = 19,
    parameter int R_IN  = 2,
    parameter int R_OUT = 4
) (
    input logic        clk,
    input logic        rst,
    point_pack_if.slave pp
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic signed [XW:0] IMG_W_S = (XW+1)'(IMG_W);
    localparam logic signed [YW:0] IMG_H_S = (YW+1)'(IMG_H);
    localparam logic signed [XW:0] RX_IN   = (XW+1)'(R_IN);
    localparam logic signed [XW:0] RX_OUT  = (XW+1)'(R_OUT);
    localparam logic signed [YW:0] RY_IN   = (YW+1)'(R_IN);
    localparam logic signed [YW:0] RY_OUT  = (YW+1)'(R_OUT);

    state_t               state_q, state_d;
    logic [3:0]           slot_q, slot_d;
    logic [XW-1:0]        cx_q, cx_d;
    logic [YW-1:0]        cy_q, cy_d;

    logic                 mem_rd_q, mem_rd_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic                 vld_p1_q, vld_p1_d;
    logic [3:0]           idx_p1_q, idx_p1_d;
    logic                 zero_p1_q, zero_p1_d;

    logic [WIDTH*9-1:0]   shadow_q, shadow_d;
    logic [WIDTH*9-1:0]   point_val_q, point_val_d;
    logic                 pv_valid_q, pv_valid_d;
    logic [XW-1:0]        pv_x_q, pv_x_d;
    logic [YW-1:0]        pv_y_q, pv_y_d;

    logic signed [XW:0]   dx, sx;
    logic signed [YW:0]   dy, sy;
    logic [XW-1:0]        px;
    logic [YW-1:0]        py;
    logic                 rd;
    logic [AW-1:0]        addr;

`ifdef POINT_PACK_CLAMP_EN
    function automatic logic [XW-1:0] clamp_x(input logic signed [XW:0] v);
        if (v[XW])           return '0;
        else if (v >= IMG_W_S) return XW'(IMG_W - 1);
        else                 return v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic signed [YW:0] v);
        if (v[YW])           return '0;
        else if (v >= IMG_H_S) return YW'(IMG_H - 1);
        else                 return v[YW-1:0];
    endfunction
`endif

    // Stage p0: slot offset, signed coordinate with guard bit, range decision, address
    always_comb begin
        dx = '0;
        dy = '0;
        case (slot_q)
            4'd1: dx =  RX_IN;
            4'd2: dy = -RY_IN;
            4'd3: dx = -RX_IN;
            4'd4: dy =  RY_IN;
            4'd5: dx =  RX_OUT;
            4'd6: dy = -RY_OUT;
            4'd7: dx = -RX_OUT;
            4'd8: dy =  RY_OUT;
            default: ;
        endcase
        sx = $signed({1'b0, cx_q}) + dx;
        sy = $signed({1'b0, cy_q}) + dy;
`ifdef POINT_PACK_CLAMP_EN
        px = clamp_x(sx);
        py = clamp_y(sy);
        rd = 1'b1;
`else
        px = sx[XW-1:0];
        py = sy[YW-1:0];
        rd = !(sx[XW] || (sx >= IMG_W_S) || sy[YW] || (sy >= IMG_H_S));
`endif
        addr = AW'(py) * AW'(IMG_W) + AW'(px);
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        vld_p1_d   = 1'b0;
        idx_p1_d   = slot_q;
        zero_p1_d  = !rd;
        case (state_q)
            IDLE: begin
                if (pp.start) begin
                    cx_d    = pp.cand_x;
                    cy_d    = pp.cand_y;
                    slot_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_d   = rd;
                mem_addr_d = rd ? addr : '0;
                vld_p1_d   = 1'b1;
                slot_d     = slot_q + 4'd1;
                if (slot_q == 4'd8) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: read data (or zero for skipped slots) lands in its field
    always_comb begin
        shadow_d    = shadow_q;
        point_val_d = point_val_q;
        pv_x_d      = pv_x_q;
        pv_y_d      = pv_y_q;
        pv_valid_d  = 1'b0;
        if (vld_p1_q) begin
            shadow_d[int'(idx_p1_q)*WIDTH +: WIDTH] = zero_p1_q ? '0 : pp.mem_data;
            if (idx_p1_q == 4'd8) begin
                point_val_d = shadow_d;
                pv_x_d      = cx_q;
                pv_y_d      = cy_q;
                pv_valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            vld_p1_q    <= 1'b0;
            pv_valid_q  <= 1'b0;
            point_val_q <= '0;
            pv_x_q      <= '0;
            pv_y_q      <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            vld_p1_q    <= vld_p1_d;
            pv_valid_q  <= pv_valid_d;
            point_val_q <= point_val_d;
            pv_x_q      <= pv_x_d;
            pv_y_q      <= pv_y_d;
        end
    end

    // Every field is rewritten per candidate, so the shadow needs no reset
    always_ff @(posedge clk) begin
        cx_q      <= cx_d;
        cy_q      <= cy_d;
        idx_p1_q  <= idx_p1_d;
        zero_p1_q <= zero_p1_d;
        shadow_q  <= shadow_d;
    end

    assign pp.busy      = (state_q != IDLE);
    assign pp.mem_rd    = mem_rd_q;
    assign pp.mem_addr  = mem_addr_q;
    assign pp.point_val = point_val_q;
    assign pp.pv_valid  = pv_valid_q;
    assign pp.pv_x      = pv_x_q;
    assign pp.pv_y      = pv_y_q;
endmodule

// File: tb/tb_point_pack.sv
// Randomised and directed bench for point_pack against a coordinate-level reference model.
// Memory serves pixel(x,y) = (x+y) mod 256 to the read issued in the same cycle.
module tb_point_pack;
    localparam int WIDTH = 8;
    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int AW    = 19;
    localparam int R_IN  = 2;
    localparam int R_OUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    point_pack_if #(.WIDTH(WIDTH), .XW(XW), .YW(YW), .AW(AW)) pp_if ();

    point_pack #(
        .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW),
        .AW(AW), .R_IN(R_IN), .R_OUT(R_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pp  (pp_if)
    );

    function automatic logic [WIDTH-1:0] pix_of_addr(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        return WIDTH'(((ai % IMG_W) + (ai / IMG_W)) % 256);
    endfunction

    // Junk on idle cycles so a skipped slot that still captures is visible
    assign pp_if.mem_data = pp_if.mem_rd ? pix_of_addr(pp_if.mem_addr) : 8'hA5;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int ox[9] = '{0, R_IN, 0, -R_IN, 0, R_OUT, 0, -R_OUT, 0};
    int oy[9] = '{0, 0, -R_IN, 0, R_IN, 0, -R_OUT, 0, R_OUT};
    int int_f[9] = '{150, 152, 148, 148, 152, 154, 146, 146, 154};
`ifdef POINT_PACK_CLAMP_EN
    int corner_f[9]  = '{2, 4, 1, 1, 4, 6, 1, 1, 6};
    int corner_rd[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    int corner_f[9]  = '{2, 4, 0, 0, 4, 6, 0, 0, 6};
    int corner_rd[9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
`endif

    int exp_rd[9], exp_addr[9], exp_val[9];
    int obs_rd[9], obs_addr[9];

    task automatic model(input int cx, input int cy);
        for (int k = 0; k < 9; k++) begin
            int x;
            int y;
            x = cx + ox[k];
            y = cy + oy[k];
`ifdef POINT_PACK_CLAMP_EN
            if (x < 0) x = 0;
            if (x > IMG_W - 1) x = IMG_W - 1;
            if (y < 0) y = 0;
            if (y > IMG_H - 1) y = IMG_H - 1;
            exp_rd[k]   = 1;
            exp_addr[k] = y * IMG_W + x;
            exp_val[k]  = (x + y) % 256;
`else
            if (x >= 0 && x < IMG_W && y >= 0 && y < IMG_H) begin
                exp_rd[k]   = 1;
                exp_addr[k] = y * IMG_W + x;
                exp_val[k]  = (x + y) % 256;
            end else begin
                exp_rd[k]   = 0;
                exp_addr[k] = 0;
                exp_val[k]  = 0;
            end
`endif
        end
    endtask

    function automatic int fld(input int k);
        return int'(pp_if.point_val[k*WIDTH +: WIDTH]);
    endfunction

    task automatic check_fields(input string pfx, input int cx, input int cy);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_f%0d", pfx, k), longint'(fld(k)), longint'(exp_val[k]));
        check({pfx, "_pv_x"}, longint'(pp_if.pv_x), longint'(cx));
        check({pfx, "_pv_y"}, longint'(pp_if.pv_y), longint'(cy));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},      longint'(pp_if.busy), 0);
        check({pfx, "_mem_rd"},    longint'(pp_if.mem_rd), 0);
        check({pfx, "_mem_addr"},  longint'(pp_if.mem_addr), 0);
        check({pfx, "_point_val"}, longint'(pp_if.point_val != '0), 0);
        check({pfx, "_pv_valid"},  longint'(pp_if.pv_valid), 0);
        check({pfx, "_pv_x"},      longint'(pp_if.pv_x), 0);
        check({pfx, "_pv_y"},      longint'(pp_if.pv_y), 0);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after edge N+11
    task automatic run_cand(input string pfx, input int cx, input int cy);
        model(cx, cy);
        pp_if.start  = 1'b1;
        pp_if.cand_x = XW'(cx);
        pp_if.cand_y = YW'(cy);
        @(posedge clk); #1;
        pp_if.start = 1'b0;
        check({pfx, "_busy_hi"}, longint'(pp_if.busy), 1);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            obs_rd[k]   = int'(pp_if.mem_rd);
            obs_addr[k] = int'(pp_if.mem_addr);
            check($sformatf("%s_rd%0d", pfx, k), longint'(obs_rd[k]), longint'(exp_rd[k]));
            if (exp_rd[k] != 0)
                check($sformatf("%s_addr%0d", pfx, k), longint'(obs_addr[k]), longint'(exp_addr[k]));
            check($sformatf("%s_early_vld%0d", pfx, k), longint'(pp_if.pv_valid), 0);
        end
        @(posedge clk); #1;
        check({pfx, "_pv_valid"}, longint'(pp_if.pv_valid), 1);
        check({pfx, "_busy_lo"}, longint'(pp_if.busy), 0);
        check_fields(pfx, cx, cy);
        @(posedge clk); #1;
        check({pfx, "_pv_valid_clr"}, longint'(pp_if.pv_valid), 0);
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 5));
            1:       return int'($urandom_range(IMG_W - 6, IMG_W - 1));
            default: return int'($urandom_range(0, IMG_W - 1));
        endcase
    endfunction

    function automatic int rand_y();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 5));
            1:       return int'($urandom_range(IMG_H - 6, IMG_H - 1));
            default: return int'($urandom_range(0, IMG_H - 1));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    initial begin
        int nvld;
        int seen_x;
        int hx[44];
        int hy[44];

        rst          = 1'b1;
        pp_if.start  = 1'b0;
        pp_if.cand_x = '0;
        pp_if.cand_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Interior candidate against the worked values
        run_cand("interior", 100, 50);
        check("interior_slot0_addr", longint'(obs_addr[0]), 32100);
        for (int k = 0; k < 9; k++)
            check($sformatf("interior_const_f%0d", k), longint'(fld(k)), longint'(int_f[k]));

        // Corner candidate: skipped or clamped reads
        run_cand("corner", 1, 1);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("corner_const_f%0d", k), longint'(fld(k)), longint'(corner_f[k]));
            check($sformatf("corner_const_rd%0d", k), longint'(obs_rd[k]), longint'(corner_rd[k]));
        end

        // Second start while busy must be dropped
        pp_if.start  = 1'b1;
        pp_if.cand_x = XW'(100);
        pp_if.cand_y = YW'(50);
        @(posedge clk); #1;
        pp_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pp_if.start  = 1'b1;
        pp_if.cand_x = XW'(200);
        pp_if.cand_y = YW'(10);
        @(posedge clk); #1;
        pp_if.start = 1'b0;
        nvld   = 0;
        seen_x = -1;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk); #1;
            if (pp_if.pv_valid) begin
                nvld++;
                seen_x = int'(pp_if.pv_x);
            end
        end
        check("ignore_vld_count", longint'(nvld), 1);
        check("ignore_pv_x", longint'(seen_x), 100);

        // start held high: one accepted candidate every 11 cycles
        pp_if.start = 1'b1;
        for (int c = 0; c < 44; c++) begin
            hx[c] = rand_x();
            hy[c] = rand_y();
            pp_if.cand_x = XW'(hx[c]);
            pp_if.cand_y = YW'(hy[c]);
            @(posedge clk); #1;
            if (c % 11 == 10) begin
                check($sformatf("b2b_vld%0d", c), longint'(pp_if.pv_valid), 1);
                model(hx[c-10], hy[c-10]);
                check_fields($sformatf("b2b%0d", c), hx[c-10], hy[c-10]);
            end else begin
                check($sformatf("b2b_novld%0d", c), longint'(pp_if.pv_valid), 0);
            end
        end
        pp_if.start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_cand($sformatf("rand%0d", i), rand_x(), rand_y());

        // Reset while slot 5 is on the read port
        pp_if.start  = 1'b1;
        pp_if.cand_x = XW'(300);
        pp_if.cand_y = YW'(200);
        @(posedge clk); #1;
        pp_if.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_rd_slot5", longint'(pp_if.mem_addr), 200 * IMG_W + 300 + R_OUT);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        nvld = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (pp_if.pv_valid) nvld++;
        end
        check("midrst_no_vld", longint'(nvld), 0);
        run_cand("post_rst", 100, 50);
        for (int k = 0; k < 9; k++)
            check($sformatf("post_rst_const_f%0d", k), longint'(fld(k)), longint'(int_f[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/point_pack.md
# point_pack

Candidate-point sampler that generates the packed nine-field `point_val` word consumed by the score calculator. For each requested candidate centre it reads nine pixels from image memory through a single read port: the centre, four inner-ring points and four outer-ring points. It packs them in scorer field order and presents the word with a one-cycle valid strobe. It sits between the candidate generator and the scoring pipeline.

## Interface
- Parameters:
  - `WIDTH`, 8: pixel/field width.
  - `IMG_W`, 640: image width in pixels.
  - `IMG_H`, 480: image height in pixels.
  - `XW`, 10: x-coordinate width.
  - `YW`, 9: y-coordinate width.
  - `AW`, 19: memory address width.
  - `R_IN`, 2: inner-ring radius in pixels.
  - `R_OUT`, 4: outer-ring radius in pixels (`R_OUT` > `R_IN`).
- Ports:
  - `clk` in 1: the single clock.
  - `rst` in 1: reset, synchronous and active-high.
  - `start` in 1: request a new candidate; sampled only when `busy`=0.
  - `cand_x` in `XW`: candidate centre x, sampled with `start`.
  - `cand_y` in `YW`: candidate centre y, sampled with `start`.
  - `busy` out 1: candidate in flight.
  - `mem_rd` out 1: memory read strobe.
  - `mem_addr` out `AW`: read address, y*`IMG_W`+x.
  - `mem_data` in `WIDTH`: read data, valid exactly 1 cycle after `mem_rd`.
  - `point_val` out `WIDTH`*9: packed fields. Field k occupies [`WIDTH`*(k+1)-1 : `WIDTH`*k]: k=0 boundary (centre), 1–4 in1–in4, 5–8 out1–out4.
  - `pv_valid` out 1: one-cycle strobe, `point_val` complete.
  - `pv_x` out `XW`: centre x belonging to the current `point_val`.
  - `pv_y` out `YW`: centre y belonging to the current `point_val`.

## Operation
- FSM states IDLE → ISSUE → DRAIN → IDLE.
  - IDLE: `start`=1 latches `cand_x`/`cand_y`, clears slot index to 0 and moves to ISSUE; `busy` goes high.
  - ISSUE: one slot per cycle, index 0..8. Slot 8 moves to DRAIN.
  - DRAIN: captures the final datum, updates outputs, then returns to IDLE.
- Slot order and coordinates, with centre (x,y):
  - 0 boundary: (x,y)
  - 1 in1: (x+R_IN, y)
  - 2 in2: (x, y−R_IN)
  - 3 in3: (x−R_IN, y)
  - 4 in4: (x, y+R_IN)
  - 5–8 out1–out4: same pattern using `R_OUT`.
- Coordinate arithmetic is signed with one guard bit. A slot is out of range if x<0, x≥`IMG_W`, y<0 or y≥`IMG_H`.
- Out-of-range slot, default build: `mem_rd`=0 for that slot and the field is written 0. Per-slot out-of-range flag and index are delayed one cycle alongside the read.
- In-range slot: `mem_rd`=1, and `mem_data` is captured into field (slot index) one cycle later.
- Fields are accumulated in an internal shadow register. `point_val`, `pv_x` and `pv_y` load together with `pv_valid` and hold until the next completion.
- `start` while `busy`=1 is ignored, not queued.
- `rst` at any time forces IDLE, discards in-flight reads, and sets every output to 0: `busy`, `mem_rd`, `mem_addr`, `point_val`, `pv_valid`, `pv_x`, `pv_y`.

## Timing
- Let `start` be sampled at edge N.
- `mem_rd`/`mem_addr` are registered and present slots 0..8 in the cycles following edges N+1..N+9.
- `mem_data` is captured at edges N+2..N+10.
- `pv_valid`=1, `point_val`, `pv_x` and `pv_y` update at edge N+10; `pv_valid` clears at N+11.
- `busy`=1 from edge N to edge N+10. The earliest next `start` sample is at edge N+11.
- Throughput: one candidate per 11 cycles. Latency from `start` to `pv_valid`: 10 cycles.

## Configuration
- `POINT_PACK_CLAMP_EN`:
  - Defined: out-of-range coordinates are clamped per axis to [0,`IMG_W`−1] and [0,`IMG_H`−1]. The clamped pixel is read, so `mem_rd`=1 for all nine slots.
  - Undefined: out-of-range slots skip the read and pack 0.
  - Timing is identical in both builds.

## Test plan
Memory model for all scenarios: pixel(x,y) = (x+y) mod 256, 1-cycle read latency.
- Interior candidate: `start` with (100,50).
  - Slot-0 `mem_addr` = 32100.
  - `pv_valid` 10 cycles later.
  - Fields 0..8 = 150,152,148,148,152,154,146,146,154.
  - `pv_x`/`pv_y` = 100/50.
- Corner candidate (1,1), macro undefined:
  - Fields 0..8 = 2,4,0,0,4,6,0,0,6.
  - `mem_rd` low in slots 2,3,6,7.
- Corner candidate (1,1), `POINT_PACK_CLAMP_EN` defined:
  - Fields 0..8 = 2,4,1,1,4,6,1,1,6.
  - `mem_rd` high in all 9 slots.
- `start` at (100,50), then `start` at (200,10) asserted 3 cycles later:
  - Second request is ignored.
  - Only one `pv_valid` appears, with `pv_x`=100.
- Back-to-back: `start` held high continuously.
  - `pv_valid` strobes every 11 cycles, each with correct fields.
- `rst` pulsed during slot 5 of a candidate:
  - No `pv_valid`; all outputs 0 the cycle after reset.
  - A following `start` at (100,50) completes normally with the interior values above.
